// File: rtl/truth_table_checker.sv
// Purpose : sweeps {w,x,y,z} 0000..1111 into a combinational unit and checks F1/F2 against EXP_F1/EXP_F2.
// Latency : done rises 16*STEP_CYCLES edges after the edge that samples start; F1/F2 sampled on the last cycle of each step.
// Backpr. : none; start is accepted only in IDLE or DONE and is ignored while a sweep runs.
//
// Ports:
//   clk, rst_n        - clock and synchronous active-low reset
//   start             - begin a sweep (IDLE/DONE only)
//   w, x, y, z        - registered stimulus vector, w is the MSB
//   F1, F2            - responses from the unit under test
//   busy, done, pass  - sweep status; pass is meaningful while done
//   err_count         - mismatching vectors this sweep, 0..16
//   fail_valid        - at least one mismatch recorded
//   first_fail_idx    - index of the first mismatching vector
module truth_table_checker #(
  parameter int          STEP_CYCLES = 4,
  parameter logic [15:0] EXP_F1      = 16'h0000,
  parameter logic [15:0] EXP_F2      = 16'h0000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       w,
  output logic       x,
  output logic       y,
  output logic       z,
  input  logic       F1,
  input  logic       F2,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [4:0] err_count,
  output logic       fail_valid,
  output logic [3:0] first_fail_idx
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [7:0] LAST_CNT = 8'(STEP_CYCLES - 1);

  state_t     state;
  logic [3:0] idx;
  logic [7:0] cnt;

  // Combinational view of the compare made at the end of a step.
  logic       mismatch;
  logic [4:0] err_next;

  always_comb begin
    mismatch = (F1 != EXP_F1[idx]) || (F2 != EXP_F2[idx]);
    err_next = err_count + {4'd0, mismatch};
  end

  // The vector is the idx register itself, so it only moves at step
  // boundaries and naturally holds 1111 once the sweep finishes.
  assign {w, x, y, z} = idx;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      idx            <= 4'd0;
      cnt            <= 8'd0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_count      <= 5'd0;
      fail_valid     <= 1'b0;
      first_fail_idx <= 4'd0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state          <= RUN;
            idx            <= 4'd0;
            cnt            <= 8'd0;
            busy           <= 1'b1;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_count      <= 5'd0;
            fail_valid     <= 1'b0;
            first_fail_idx <= 4'd0;
          end
        end

        RUN: begin
          if (cnt == LAST_CNT) begin
            err_count <= err_next;
            if (mismatch && !fail_valid) begin
              fail_valid     <= 1'b1;
              first_fail_idx <= idx;
            end
            if (idx == 4'd15) begin
              // pass must reflect this final compare, hence err_next.
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (err_next == 5'd0);
            end else begin
              idx <= idx + 4'd1;
              cnt <= 8'd0;
            end
          end else begin
            cnt <= cnt + 8'd1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/truth_table_checker.md
Name: truth_table_checker

Overview:
- Hardware stimulus/response engine for a 4-input, 2-output combinational unit under test.
- Drives every {w,x,y,z} combination, 0000 through 1111, in ascending order, holding each for a fixed settle time.
- Samples F1/F2 at the end of each step and compares them against parameterised expected truth tables.
- Reports pass/fail, error count and first failing vector, so lab boards can self-check without a simulator.

Parameters:
- STEP_CYCLES, 4, clock cycles each vector is held. Legal range 1..255. Sampling occurs on the last cycle of the step.
- EXP_F1, 16'h0000, expected F1 truth table. Bit i is the expected value for vector i, with i = {w,x,y,z} and w as MSB.
- EXP_F2, 16'h0000, expected F2 truth table. Same indexing as EXP_F1.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst_n  input  1  synchronous, active-low reset.
- start  input  1  begins a sweep. Sampled only in IDLE or DONE.
- w  output  1  vector bit 3 (MSB) to the unit under test.
- x  output  1  vector bit 2.
- y  output  1  vector bit 1.
- z  output  1  vector bit 0.
- F1  input  1  unit-under-test output 1.
- F2  input  1  unit-under-test output 2.
- busy  output  1  high while a sweep is running.
- done  output  1  high from sweep completion until the next start or reset.
- pass  output  1  valid while done: 1 when err_count == 0.
- err_count  output  5  number of mismatching vectors, 0..16. A vector counts once even if both F1 and F2 mismatch.
- fail_valid  output  1  high once at least one mismatch has been recorded this sweep.
- first_fail_idx  output  4  index of the first mismatching vector. Meaningful only when fail_valid = 1.

Behaviour:
- Reset (rst_n = 0 at a clock edge):
  - state = IDLE; idx, step counter, w/x/y/z, busy, done, pass, err_count, fail_valid and first_fail_idx all return to 0.
  - Reset applies from any state, including mid-sweep. Partial results are discarded.
- FSM states: IDLE, RUN, DONE.
- IDLE/DONE with start = 1:
  - Next state RUN; idx = 0; cnt = 0; busy = 1; done = 0; pass = 0.
  - err_count, fail_valid and first_fail_idx clear to 0.
  - {w,x,y,z} = 0000 from the same edge.
- RUN:
  - {w,x,y,z} = idx is registered and changes only at step boundaries.
  - cnt increments every cycle.
  - When cnt == STEP_CYCLES-1, at that edge:
    - Compare F1 with EXP_F1[idx] and F2 with EXP_F2[idx].
    - On mismatch: err_count += 1. If fail_valid = 0, set first_fail_idx = idx and fail_valid = 1.
    - If idx == 15: state DONE, busy = 0, done = 1, pass = (final err_count == 0). The final err_count includes this last compare.
    - Otherwise: idx += 1, cnt = 0.
- Latency: done rises exactly 16*STEP_CYCLES edges after the edge that sampled start. busy stays high for exactly that span.
- start while in RUN is ignored and does not restart the sweep.
- DONE:
  - Vector outputs hold 1111.
  - Result outputs are stable until the next start or reset.
- STEP_CYCLES = 1: the vector changes every cycle, and F1/F2 are sampled in the same cycle the vector is presented. The unit under test must be purely combinational with zero registered delay.
- err_count width: 5 bits, so a value of 16 cannot wrap.
- idx wrap from 15 to 0 never occurs inside a sweep.

Test Plan:
- Matching model: model F1 = w^x^y^z and F2 = w&x, with EXP_F1 = 16'h6996, EXP_F2 = 16'hF000, STEP_CYCLES = 4, pulse start -> busy high for 64 cycles; vectors step 0..15 every 4 cycles; done = 1, pass = 1, err_count = 0, fail_valid = 0.
- Stuck-at fault: same parameters, model F2 stuck at 0 -> done = 1, pass = 0, err_count = 4, fail_valid = 1, first_fail_idx = 12.
- All-wrong case: EXP_F1 = 16'hFFFF against F1 tied to 0 and F2 matching -> err_count = 16, first_fail_idx = 0, pass = 0.
- Start ignored and restart: pulse start again at cycle 20 of a sweep -> no effect, done still at cycle 64. Then start from DONE -> counters clear and an identical second sweep runs.
- Reset mid-run: rst_n = 0 at cycle 30 -> next edge all outputs 0 and state IDLE. Then start -> full 64-cycle sweep with correct results.
- Minimum step: STEP_CYCLES = 1 with the matching model -> done after exactly 16 cycles, pass = 1.
